// File: rtl/quat_mult_pipe_if.sv
// rtl/quat_mult_pipe_if.sv - operand/result handshake bundle for the quaternion multiplier
interface quat_mult_pipe_if #(
  parameter int W     = 16,
  parameter int TAG_W = 4
);
  logic                    in_valid;
  logic                    in_ready;
  logic                    in_conj;
  logic [TAG_W-1:0]        in_tag;
  logic signed [W-1:0]     a0, a1, a2, a3;
  logic signed [W-1:0]     b0, b1, b2, b3;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [W-1:0]     r0, r1, r2, r3;
  logic [TAG_W-1:0]        out_tag;
  logic [3:0]              out_sat;

  modport slave (
    input  in_valid, in_conj, in_tag, a0, a1, a2, a3, b0, b1, b2, b3, out_ready,
    output in_ready, out_valid, r0, r1, r2, r3, out_tag, out_sat
  );

  modport master (
    output in_valid, in_conj, in_tag, a0, a1, a2, a3, b0, b1, b2, b3, out_ready,
    input  in_ready, out_valid, r0, r1, r2, r3, out_tag, out_sat
  );
endinterface

// File: rtl/quat_mult_pipe.sv
// rtl/quat_mult_pipe.sv - 3-stage pipelined Hamilton product with conj, round/saturate
module quat_mult_pipe #(
  parameter int W     = 16,
  parameter int FRAC  = 14,
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  quat_mult_pipe_if.slave  bus,
  input  logic             sat_clr,
  output logic [CNT_W-1:0] sat_count
);
  localparam int PW = 2 * W;
  localparam int SW = 2 * W + 2;
  localparam logic signed [SW-1:0] RND  = (FRAC > 0) ? (SW'(1) <<< ((FRAC > 0) ? FRAC - 1 : 0)) : '0;
  localparam logic signed [SW-1:0] MAXV = (SW'(1) <<< (W - 1)) - SW'(1);
  localparam logic signed [SW-1:0] MINV = -(SW'(1) <<< (W - 1));

  logic                    en;
  logic signed [W-1:0]     a_c [4];
  logic signed [W-1:0]     b_c [4];

  logic                    v1_q, v1_d, conj1_q, conj1_d;
  logic [TAG_W-1:0]        tag1_q, tag1_d;
  logic signed [PW-1:0]    p1_q [16];
  logic signed [PW-1:0]    p1_d [16];

  logic                    v2_q, v2_d;
  logic [TAG_W-1:0]        tag2_q, tag2_d;
  logic signed [SW-1:0]    e [16];
  logic signed [SW-1:0]    s2_q [4];
  logic signed [SW-1:0]    s2_d [4];

  logic                    v3_q, v3_d;
  logic [TAG_W-1:0]        tag3_q, tag3_d;
  logic signed [SW-1:0]    rnd_v [4];
  logic signed [W-1:0]     r3_q [4];
  logic signed [W-1:0]     r3_d [4];
  logic [3:0]              sat3_q, sat3_d;

  logic [CNT_W-1:0]        cnt_q, cnt_d;

  // Whole pipeline advances together whenever the output slot is free or draining.
  assign en           = !v3_q || bus.out_ready;
  assign bus.in_ready = en;
  assign bus.out_valid = v3_q;
  assign bus.r0       = r3_q[0];
  assign bus.r1       = r3_q[1];
  assign bus.r2       = r3_q[2];
  assign bus.r3       = r3_q[3];
  assign bus.out_tag  = tag3_q;
  assign bus.out_sat  = sat3_q;
  assign sat_count    = cnt_q;

  // S1: the sixteen full-precision component products, index = 4*i + j for ai*bj.
  always_comb begin
    a_c[0] = bus.a0; a_c[1] = bus.a1; a_c[2] = bus.a2; a_c[3] = bus.a3;
    b_c[0] = bus.b0; b_c[1] = bus.b1; b_c[2] = bus.b2; b_c[3] = bus.b3;
    v1_d    = v1_q;
    conj1_d = conj1_q;
    tag1_d  = tag1_q;
    p1_d    = p1_q;
    if (en) begin
      v1_d    = bus.in_valid;
      conj1_d = bus.in_conj;
      tag1_d  = bus.in_tag;
      for (int i = 0; i < 4; i++) begin
        for (int j = 0; j < 4; j++) begin
          p1_d[4*i+j] = PW'(a_c[i]) * PW'(b_c[j]);
        end
      end
    end
  end

  // S2: signed sums; conj flips every term whose A factor is a vector part (i >= 1).
  always_comb begin
    for (int k = 0; k < 16; k++) begin
      e[k] = SW'(p1_q[k]);
      if (conj1_q && k >= 4) e[k] = -e[k];
    end
    v2_d   = v2_q;
    tag2_d = tag2_q;
    s2_d   = s2_q;
    if (en) begin
      v2_d    = v1_q;
      tag2_d  = tag1_q;
      s2_d[0] = e[0] - e[5] - e[10] - e[15];
      s2_d[1] = e[1] + e[4] + e[11] - e[14];
      s2_d[2] = e[2] - e[7] + e[8]  + e[13];
      s2_d[3] = e[3] + e[6] - e[9]  + e[12];
    end
  end

  // S3: round half up, shift to the component format, clamp; data holds across bubbles.
  always_comb begin
    v3_d   = v3_q;
    tag3_d = tag3_q;
    r3_d   = r3_q;
    sat3_d = sat3_q;
    for (int k = 0; k < 4; k++) begin
      rnd_v[k] = (s2_q[k] + RND) >>> FRAC;
    end
    if (en) begin
      v3_d = v2_q;
      if (v2_q) begin
        tag3_d = tag2_q;
        for (int k = 0; k < 4; k++) begin
          sat3_d[k] = 1'b0;
          if (rnd_v[k] > MAXV) begin
            rnd_v[k]  = MAXV;
            sat3_d[k] = 1'b1;
          end else if (rnd_v[k] < MINV) begin
            rnd_v[k]  = MINV;
            sat3_d[k] = 1'b1;
          end
          r3_d[k] = rnd_v[k][W-1:0];
        end
      end
    end
  end

  // Saturation event counter: clear has priority, count sticks at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (sat_clr) begin
      cnt_d = '0;
    end else if (v3_q && bus.out_ready && (|sat3_q) && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers for all three stages and the counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      conj1_q <= 1'b0;
      tag1_q  <= '0;
      v2_q    <= 1'b0;
      tag2_q  <= '0;
      v3_q    <= 1'b0;
      tag3_q  <= '0;
      sat3_q  <= '0;
      cnt_q   <= '0;
      for (int k = 0; k < 16; k++) p1_q[k] <= '0;
      for (int k = 0; k < 4; k++) begin
        s2_q[k] <= '0;
        r3_q[k] <= '0;
      end
    end else begin
      v1_q    <= v1_d;
      conj1_q <= conj1_d;
      tag1_q  <= tag1_d;
      v2_q    <= v2_d;
      tag2_q  <= tag2_d;
      v3_q    <= v3_d;
      tag3_q  <= tag3_d;
      sat3_q  <= sat3_d;
      cnt_q   <= cnt_d;
      p1_q    <= p1_d;
      s2_q    <= s2_d;
      r3_q    <= r3_d;
    end
  end
endmodule

// File: doc/quat_mult_pipe.md
Name: quat_mult_pipe

Overview:
Parametrised, fully pipelined Hamilton-product quaternion multiplier, r = A x B (or conj(A) x B), on signed fixed-point components. It is the next generation of the quaternion math datapath. It uses its own integer multipliers instead of per-product floating-point IP cores. It adds a valid/ready handshake with backpressure, conjugate mode, round/saturate, a sideband tag, and a saturation counter. It sits between the sensor-fusion front end and the attitude integrator.

Parameters:
W, 16, component width in bits (signed two's complement), 8..32
FRAC, 14, fractional bits of the component format, 0..W-1 (Q(W-FRAC).FRAC)
TAG_W, 4, sideband tag width carried alongside each operation, >=1
CNT_W, 16, saturation event counter width

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand pair valid
in_ready  out  1  block accepts operands this cycle
in_conj  in  1  1: compute conj(A) x B; 0: compute A x B
in_tag  in  TAG_W  sideband, returned unchanged with the result
a0,a1,a2,a3  in  W each  A components (w,x,y,z)
b0,b1,b2,b3  in  W each  B components (w,x,y,z)
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
r0,r1,r2,r3  out  W each  result components
out_tag  out  TAG_W  tag of the result
out_sat  out  4  per-component saturation flags for this result (bit k = rk)
sat_count  out  CNT_W  number of results with any out_sat bit set; saturates at all-ones
sat_clr  in  1  synchronous clear of sat_count

Behaviour:
- Reset (async assert, sync-safe deassert): all valid bits 0; r*, out_tag, out_sat, sat_count and all pipeline registers 0. in_ready is 1 in the first cycle after reset.
- Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
- Pipeline: 3 stages (S1 products, S2 signed sums, S3 round/saturate). Latency is exactly 3 cycles from accept to out_valid when unstalled. Throughput is 1 per cycle.
- Stall: en = !out_valid | out_ready. All stage registers, including per-stage valid/conj/tag, load only when en=1. in_ready = en (combinational). Bubbles advance normally when en=1.
- S1: register the 16 full-precision signed products ai*bj (2W bits each) with the stage's conj bit and tag.
- S2: sums at 2W+2 bits, no overflow possible:
  r0 = a0b0 - a1b1 - a2b2 - a3b3
  r1 = a0b1 + a1b0 + a2b3 - a3b2
  r2 = a0b2 - a1b3 + a2b0 + a3b1
  r3 = a0b3 + a1b2 - a2b1 + a3b0
- Conj mode: negate every product containing a1, a2 or a3 in S2 (sign flip of the term). Input components are never negated, so a = -2^(W-1) is handled exactly.
- S3 rounding: if FRAC>0, add 2^(FRAC-1), then arithmetic shift right by FRAC (round half toward +inf). If FRAC=0, no rounding.
- S3 saturation: clamp to [-2^(W-1), 2^(W-1)-1] and set the matching out_sat bit when clamped.
- sat_count increments by 1 on each output transfer with |out_sat=1. It holds at 2^CNT_W-1.
- sat_clr: when high, sat_count <= 0. If sat_clr coincides with an increment, the clear wins.
- Outputs are held stable while out_valid & !out_ready. r*, out_tag and out_sat hold their last value when out_valid=0.
- in_valid while in_ready=0: the operand is not taken. The source must hold it.
- Reset mid-operation: all in-flight results are discarded with no partial output; sat_count clears.

Test Plan:
- W=16, FRAC=14, unit values (16384 = 1.0): A=i (0,16384,0,0), B=j (0,0,16384,0), conj=0 -> r=(0,0,0,16384) exactly 3 cycles after accept, out_sat=0.
- Same operands with in_conj=1 -> r=(0,0,0,-16384). Then A=(16384,0,0,0), B=(8192,-8192,4096,-4096), conj=1 -> r=B unchanged.
- Saturation: A=(32767,32767,32767,32767), B=(32767,-32767,-32767,-32767) -> r0=32767, out_sat[0]=1, sat_count increments by 1. Then A=(-32768,0,0,0), B=(-32768,0,0,0) -> r0=32767 with out_sat[0]=1.
- Backpressure: stream 10 random operand pairs with tags 0..9 while out_ready toggles 1,0,0,1 repeating -> all 10 results arrive in order, match the reference model and tags, with no loss or duplication, and held stable during stalls. With out_ready=0 for 4+ cycles, in_ready=0 once out_valid=1.
- Rounding, FRAC=14: A=(1,0,0,0), B=(8192,0,0,0) -> r0=1 (0.5 LSB rounds up). B=(8191,0,0,0) -> r0=0. A=(-1,0,0,0), B=(8192,0,0,0) -> r0=0.
- Reset mid-stream: assert rst_n=0 with 3 operations in flight -> out_valid=0 immediately, no stale result after release. Also sat_count at max plus another saturating result holds at max, and sat_clr with a simultaneous increment gives 0.
